// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - shared fixed-point defaults and divider state type
package fixed_pkg;

    localparam int FRACTIONAL_SIZE = 12;
    localparam int OPERAND_SIZE    = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } fixed_div_state_t;

endpackage

// File: rtl/fixed_divide_if.sv
// rtl/fixed_divide_if.sv - operand/result handshake bundle for fixed_divide
interface fixed_divide_if
    import fixed_pkg::*;
#(
    parameter int W = OPERAND_SIZE
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] c;
    logic                overflow;
    logic                div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, overflow, div_by_zero
    );
endinterface

// File: rtl/fixed_saturate.sv
// rtl/fixed_saturate.sv - clamp an unsigned magnitude plus sign to a w-bit signed value
module fixed_saturate
    import fixed_pkg::*;
#(
    parameter int w = OPERAND_SIZE,
    parameter int n = OPERAND_SIZE + FRACTIONAL_SIZE
) (
    input  logic [n-1:0]        mag,
    input  logic                neg,
    output logic signed [w-1:0] value,
    output logic                ovf
);
    // Largest positive magnitude is 2^(w-1)-1; negative side reaches one further.
    localparam logic [n-1:0] pos_lim = {{(n-w+1){1'b0}}, {(w-1){1'b1}}};
    localparam logic [n-1:0] neg_lim = pos_lim + 1'b1;

    always_comb begin
        value = mag[w-1:0];
        ovf   = 1'b0;
        if (neg) begin
            if (mag > neg_lim) begin
                value = {1'b1, {(w-1){1'b0}}};
                ovf   = 1'b1;
            end else begin
                value = ~mag[w-1:0] + 1'b1;
            end
        end else if (mag > pos_lim) begin
            value = {1'b0, {(w-1){1'b1}}};
            ovf   = 1'b1;
        end
    end
endmodule

// File: rtl/fixed_divide.sv
// rtl/fixed_divide.sv - sequential signed Q-format divider, radix-2 restoring on magnitudes
module fixed_divide
    import fixed_pkg::*;
#(
    parameter int fractional_size = FRACTIONAL_SIZE,
    parameter int operand_size    = OPERAND_SIZE
) (
    input  logic          clk,
    input  logic          rst,
    fixed_divide_if.slave bus
);
    localparam int W  = operand_size;
    localparam int N  = operand_size + fractional_size;
    localparam int CW = $clog2(N + 1);

    fixed_div_state_t state, state_nx;

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    logic [N-1:0]        dq;
    logic [W-1:0]        dvs;
    logic [W-1:0]        rem;
    logic [CW-1:0]       cnt;
    logic                neg;
    logic                zero_div;
    logic [W:0]          rem_sh;
    logic [W-1:0]        rem_nx;
    logic                q_bit;
    logic [W-1:0]        abs_a;
    logic [W-1:0]        abs_b;
    logic                accept;
    logic signed [W-1:0] sat_c;
    logic                sat_ovf;

    assign bus.in_ready = (state == IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign abs_a        = bus.a[W-1] ? ~bus.a + 1'b1 : bus.a;
    assign abs_b        = bus.b[W-1] ? ~bus.b + 1'b1 : bus.b;
    assign rem_sh       = {rem, dq[N-1]};
    assign q_bit        = (rem_sh >= {1'b0, dvs});
    assign rem_nx       = q_bit ? W'(rem_sh - {1'b0, dvs}) : rem_sh[W-1:0];

    fixed_saturate #(.w(W), .n(N)) u_sat (
        .mag   (dq),
        .neg   (neg),
        .value (sat_c),
        .ovf   (sat_ovf)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    if (cnt == '0) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.out_valid   <= 1'b0;
            bus.c           <= '0;
            bus.overflow    <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    // A zero divisor skips the iterations and finalises on the next edge.
                    if (accept) begin
                        neg      <= bus.a[W-1] ^ bus.b[W-1];
                        dq       <= {abs_a, {fractional_size{1'b0}}};
                        dvs      <= abs_b;
                        rem      <= '0;
                        zero_div <= (bus.b == '0);
                        cnt      <= (bus.b == '0) ? '0 : CW'(N);
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        rem <= rem_nx;
                        dq  <= {dq[N-2:0], q_bit};
                        cnt <= cnt - 1'b1;
                    end else begin
                        bus.out_valid <= 1'b1;
                        if (zero_div) begin
                            bus.c           <= neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                            bus.overflow    <= 1'b0;
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            bus.c           <= sat_c;
                            bus.overflow    <= sat_ovf;
                            bus.div_by_zero <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) bus.out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_divide.sv
// tb/tb_fixed_divide.sv - directed and randomized checks of fixed_divide against an arithmetic model
module tb_fixed_divide;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fixed_divide_if #(.W(32)) bus ();

    fixed_divide #(.fractional_size(12), .operand_size(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Quotient of the real values, scaled back to Q20.12, truncated toward zero.
    function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] cv, output logic ov, output logic dz);
        longint num, den, q;
        num = longint'($signed(av)) * 64'sd4096;
        den = longint'($signed(bv));
        ov = 1'b0;
        dz = 1'b0;
        if (den == 0) begin
            dz = 1'b1;
            cv = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            q = num / den;
            if (q > 64'sd2147483647) begin
                cv = 32'h7FFF_FFFF;
                ov = 1'b1;
            end else if (q < -64'sd2147483648) begin
                cv = 32'h8000_0000;
                ov = 1'b1;
            end else begin
                cv = q[31:0];
            end
        end
    endfunction

    task automatic start_div(input logic [31:0] av, input logic [31:0] bv);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_after_handoff", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_handoff", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] ec, input logic eov, input logic edz, input int elat);
        int lat;
        start_div(av, bv);
        wait_result(lat);
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_c"}, bus.c, ec);
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(eov));
        check({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'(edz));
        handoff();
    endtask

    initial begin
        logic [31:0] ra, rb, ec;
        logic        eov, edz;
        logic [31:0] held_c;
        int          lat;
        int          seen;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_c", bus.c, 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);
        check("reset_div_by_zero", 32'(bus.div_by_zero), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        run_vec("exact",      32'd12288,         32'd8192,           32'd6144,      1'b0, 1'b0, 45);
        run_vec("trunc_neg_a", 32'(-4096),       32'd12288,          32'(-1365),    1'b0, 1'b0, 45);
        run_vec("trunc_neg_b", 32'd4096,         32'(-12288),        32'(-1365),    1'b0, 1'b0, 45);
        run_vec("ovf_pos",    32'h7FFF_FFFF,     32'd1,              32'h7FFF_FFFF, 1'b1, 1'b0, 45);
        run_vec("ovf_neg",    32'h8000_0000,     32'd1,              32'h8000_0000, 1'b1, 1'b0, 45);
        run_vec("min_by_one", 32'h8000_0000,     32'd4096,           32'h8000_0000, 1'b0, 1'b0, 45);
        run_vec("dz_neg",     32'(-5),           32'd0,              32'h8000_0000, 1'b0, 1'b1, 1);
        run_vec("dz_zero",    32'd0,             32'd0,              32'h7FFF_FFFF, 1'b0, 1'b0 | 1'b1, 1);

        // Backpressure: result must hold while the consumer stalls.
        start_div(32'd12288, 32'd4096);
        wait_result(lat);
        check("bp_latency", 32'(lat), 32'd45);
        held_c = bus.c;
        check("bp_c", held_c, 32'd12288);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_c_stable", bus.c, 32'd12288);
            check("bp_flags_stable", {30'd0, bus.overflow, bus.div_by_zero}, 32'd0);
            check("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        handoff();

        // Reset in the middle of an iteration aborts the result.
        start_div(32'd12288, 32'd8192);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_vec("after_abort", 32'(-20480), 32'd8192, 32'(-10240), 1'b0, 1'b0, 45);

        // Random operands of mixed magnitude and sign.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (i == 5) rb = '0;
            model(ra, rb, ec, eov, edz);
            run_vec("random", ra, rb, ec, eov, edz, (rb == '0) ? 1 : 45);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
